// File: rtl/mem_port_arbiter.sv
// Shares one sram-like port between instruction fetch and data access.
// In-order tag FIFO routes each response back to its requester; flushed fetches are dropped.
module mem_port_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic src;        // 0 = inst, 1 = data
        logic cancelled;
    } tag_t;

    tag_t [OUTSTANDING-1:0] fifo;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count;
    logic [SW-1:0]          starve_cnt;

    logic full, inst_elig, data_elig, grant_inst, grant_data;
    logic accept, pop;
    tag_t head;

    assign full      = (count == CW'(OUTSTANDING));
    assign inst_elig = inst_req & ~inst_cancel & ~full;
    assign data_elig = data_req & ~full;

    // Data normally wins; inst takes one grant once data has starved it long enough.
    assign grant_inst = ~reset & inst_elig & (~data_elig | (starve_cnt == SW'(STARVE_LIMIT)));
    assign grant_data = ~reset & data_elig & ~grant_inst;

    assign mem_req   = grant_inst | grant_data;
    assign mem_wr    = grant_data & data_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_wstrb = grant_data ? data_wstrb : 4'b0;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : 32'b0;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & grant_inst;
    assign data_addr_ok = accept & grant_data;

    // A cancel arriving with the head's response suppresses it in the same cycle.
    assign head         = fifo[rd_ptr];
    assign pop          = ~reset & mem_data_ok & (count != '0);
    assign inst_data_ok = pop & ~head.src & ~head.cancelled & ~inst_cancel;
    assign data_data_ok = pop & head.src;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            for (int i = 0; i < OUTSTANDING; i++)
                if (inst_cancel && !fifo[i].src)
                    fifo[i].cancelled <= 1'b1;
            if (accept) begin
                fifo[wr_ptr] <= '{src: grant_data, cancelled: 1'b0};
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (accept && !pop)
                count <= count + CW'(1);
            else if (!accept && pop)
                count <= count - CW'(1);
            if ((accept && grant_inst) || !inst_req)
                starve_cnt <= '0;
            else if (accept && grant_data && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end
endmodule
